// File: rtl/stream_range_slicer_if.sv
// Register bus and in/out stream handshakes for stream_range_slicer.
// The slave modport is the slicer's view; master is the driver's view.
interface stream_range_slicer_if #(
    parameter int DATA_W = 64
);
    logic [31:0]       i_user_data;
    logic [19:0]       i_user_addr;
    logic              i_user_wr_req;
    logic              i_user_rd_req;
    logic [31:0]       o_user_data;
    logic              o_user_rd_ack;

    logic              i_str_valid;
    logic              o_str_ack;
    logic [DATA_W-1:0] i_str_data;
    logic              o_str_valid;
    logic              i_str_ack;
    logic [DATA_W-1:0] o_str_data;

    modport slave (
        input  i_user_data, i_user_addr, i_user_wr_req, i_user_rd_req,
        output o_user_data, o_user_rd_ack,
        input  i_str_valid, i_str_data, i_str_ack,
        output o_str_ack, o_str_valid, o_str_data
    );

    modport master (
        output i_user_data, i_user_addr, i_user_wr_req, i_user_rd_req,
        input  o_user_data, o_user_rd_ack,
        output i_str_valid, i_str_data, i_str_ack,
        input  o_str_ack, o_str_valid, o_str_data
    );
endinterface

// File: rtl/stream_range_slicer.sv
// Per-lane range slicer (zero / clamp / pass / binarize) on a one-stage stream
// register, with a saturating out-of-range lane counter and a small register file.
module stream_range_slicer_lane #(
    parameter int LANE_W = 8
) (
    input  logic [LANE_W-1:0] x,
    input  logic [LANE_W-1:0] lower,
    input  logic [LANE_W-1:0] upper,
    input  logic [1:0]        mode,
    output logic [LANE_W-1:0] y,
    output logic              oor
);
    logic in_rng;

    // Strict bounds: lower >= upper leaves no value in range.
    assign in_rng = (lower < x) && (x < upper);
    assign oor    = ~in_rng;

    always_comb begin
        y = x;
        case (mode)
            2'd0: y = in_rng ? x : '0;
            2'd1: begin
                if (lower >= upper || x <= lower) y = lower;
                else if (x >= upper)              y = upper;
                else                              y = x;
            end
            2'd3: y = in_rng ? '1 : '0;
            default: y = x;
        endcase
    end
endmodule

module stream_range_slicer #(
    parameter int          DATA_W   = 64,
    parameter int          LANE_W   = 8,
    parameter logic [31:0] ID_VALUE = 32'h5A1C_0002
) (
    input  logic                  i_user_clk,
    input  logic                  i_rst,
    stream_range_slicer_if.slave  bus
);
    localparam int N  = DATA_W / LANE_W;
    localparam int CW = $clog2(N + 1);
    localparam logic [LANE_W-1:0] LO_RST = LANE_W'(64);
    localparam logic [LANE_W-1:0] HI_RST = LANE_W'(192);

    logic [LANE_W-1:0]         lower, upper;
    logic [1:0]                mode;
    logic [31:0]               oor_cnt;
    logic [N-1:0][LANE_W-1:0]  lane_out;
    logic [N-1:0]              lane_oor;
    logic [CW-1:0]             oor_num;
    logic [32:0]               cnt_sum;
    logic [31:0]               cnt_next, rd_mux;
    logic [7:0]                reg_addr;
    logic                      in_xfer, wr_lo, wr_hi, wr_mode, wr_cnt;
    logic                      unused_addr;

    genvar k;
    generate
        for (k = 0; k < N; k++) begin : g_lane
            stream_range_slicer_lane #(.LANE_W(LANE_W)) u_lane (
                .x     (bus.i_str_data[k*LANE_W +: LANE_W]),
                .lower (lower),
                .upper (upper),
                .mode  (mode),
                .y     (lane_out[k]),
                .oor   (lane_oor[k])
            );
        end
    endgenerate

    // Output register is empty during reset, so the input side stays ready.
    assign bus.o_str_ack = ~i_rst | ~bus.o_str_valid | bus.i_str_ack;
    assign in_xfer       = i_rst & bus.i_str_valid & bus.o_str_ack;

    always_comb begin
        oor_num = '0;
        for (int i = 0; i < N; i++) oor_num = oor_num + CW'(lane_oor[i]);
    end

    assign cnt_sum  = {1'b0, oor_cnt} + 33'(oor_num);
    assign cnt_next = cnt_sum[32] ? '1 : cnt_sum[31:0];

    assign reg_addr    = bus.i_user_addr[7:0];
    assign unused_addr = ^bus.i_user_addr[19:8];
    assign wr_lo   = bus.i_user_wr_req && reg_addr == 8'h00;
    assign wr_hi   = bus.i_user_wr_req && reg_addr == 8'h04;
    assign wr_mode = bus.i_user_wr_req && reg_addr == 8'h08;
    assign wr_cnt  = bus.i_user_wr_req && reg_addr == 8'h0C;

    always_ff @(posedge i_user_clk) begin
        if (!i_rst) begin
            bus.o_str_valid <= 1'b0;
            bus.o_str_data  <= '0;
        end else if (bus.o_str_ack) begin
            bus.o_str_valid <= bus.i_str_valid;
            if (bus.i_str_valid) bus.o_str_data <= lane_out;
        end
    end

    always_ff @(posedge i_user_clk) begin
        if (!i_rst) begin
            lower <= LO_RST;
            upper <= HI_RST;
            mode  <= 2'd0;
        end else begin
            if (wr_lo)   lower <= bus.i_user_data[LANE_W-1:0];
            if (wr_hi)   upper <= bus.i_user_data[LANE_W-1:0];
            if (wr_mode) mode  <= bus.i_user_data[1:0];
        end
    end

    // A clear write beats an increment landing in the same cycle.
    always_ff @(posedge i_user_clk) begin
        if (!i_rst)       oor_cnt <= '0;
        else if (wr_cnt)  oor_cnt <= '0;
        else if (in_xfer) oor_cnt <= cnt_next;
    end

    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            8'h00: rd_mux[LANE_W-1:0] = lower;
            8'h04: rd_mux[LANE_W-1:0] = upper;
            8'h08: rd_mux[1:0]        = mode;
            8'h0C: rd_mux             = oor_cnt;
            8'h10: rd_mux             = ID_VALUE;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge i_user_clk) begin
        if (!i_rst) begin
            bus.o_user_rd_ack <= 1'b0;
            bus.o_user_data   <= '0;
        end else begin
            bus.o_user_rd_ack <= bus.i_user_rd_req;
            if (bus.i_user_rd_req) bus.o_user_data <= rd_mux;
        end
    end
endmodule
